leaf_out_port_arbiter: RTL and testbench
========================================

LEAF_OUT_PORT_ARBITER -- requirements
Module: leaf_out_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of user output streams sharing one leaf interface output port; legal range 2..16.
REQ-002 Parameter PAYLOAD_BITS, default 32: stream word width, equal to the leaf interface payload width.
REQ-003 Parameter MAX_BURST, default 16: maximum beats per grant before re-arbitration; legal range 1..256.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk_user  input  1  user clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req_data  input  NUM_REQ*PAYLOAD_BITS  per-requester data; requester i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
REQ-008 req_vld  input  NUM_REQ  per-requester ap_vld.
REQ-009 req_ack  output  NUM_REQ  per-requester ap_ack.
REQ-010 out_data  output  PAYLOAD_BITS  word to the leaf interface user-to-interface data input.
REQ-011 out_vld  output  1  valid to the leaf interface.
REQ-012 out_ack  input  1  ack from the leaf interface.
REQ-013 grant_idx  output  clog2(NUM_REQ)  index of the current or most recent grantee.
REQ-014 busy  output  1  high while in GRANT.

Function
REQ-015 A beat transfers in any cycle where out_vld and out_ack are both 1.
REQ-016 The FSM SHALL have two states, IDLE and GRANT.
REQ-017 In IDLE: out_vld=0, req_ack=0; when any req_vld bit is 1, select the first set bit at or after rr_ptr (wrapping modulo NUM_REQ), load grant_idx, clear beat_cnt, and enter GRANT on the next edge.
REQ-018 In GRANT: out_data=req_data[grant_idx], out_vld=req_vld[grant_idx], req_ack[grant_idx]=out_ack, all other req_ack bits=0 (combinational path from registered grant).
REQ-019 Each transfer in GRANT increments beat_cnt by 1; beat_cnt is unchanged on cycles without a transfer.
REQ-020 GRANT exits to IDLE when a transfer occurs with beat_cnt==MAX_BURST-1, or in any cycle where req_vld[grant_idx]==0.
REQ-021 On every exit from GRANT, rr_ptr is set to (grant_idx+1) mod NUM_REQ.
REQ-022 Latency: the first beat is presentable one cycle after req_vld is sampled in IDLE; each re-arbitration costs exactly one IDLE cycle.
REQ-023 Backpressure: while out_ack=0, out_data, grant_idx and beat_cnt SHALL hold, and no requester is acked.
REQ-024 Simultaneous requests are resolved only by rr_ptr order; no requester waits longer than (NUM_REQ-1) grants.
REQ-025 Requests arriving during GRANT are ignored until the next IDLE cycle.
REQ-026 grant_idx SHALL retain its value in IDLE.
REQ-027 busy SHALL equal (state==GRANT).

Reset
REQ-028 On reset: state=IDLE, rr_ptr=0, grant_idx=0, beat_cnt=0, out_vld=0, req_ack=0, busy=0.
REQ-029 Reset asserted mid-burst aborts the grant in that cycle; no transfer is counted or acked in the reset cycle.

Structure
REQ-030 Shared package leaf_arb_pkg SHALL hold the FSM state type (IDLE, GRANT) and the default constants NUM_REQ, PAYLOAD_BITS and MAX_BURST.
REQ-031 One sub-module, rr_pick: a combinational rotating-priority selector (inputs req vector and rr_ptr; outputs index and any_req).
REQ-032 beat_cnt width SHALL be clog2(MAX_BURST)+1 so it cannot wrap.

Verification (NUM_REQ=4, MAX_BURST=4, PAYLOAD_BITS=32)
REQ-033 Reset: hold reset 2 cycles with all req_vld=1 -> out_vld=0, req_ack=0000, busy=0, grant_idx=0.
REQ-034 Single stream: requester 2 offers 0x10..0x15 with out_ack=1 -> beats 0x10..0x13, one IDLE cycle, then 0x14,0x15; grant_idx=2 throughout.
REQ-035 Full contention: all four stream continuously with out_ack=1 -> grant order 0,1,2,3,0, 4 beats each, single IDLE bubble between grants.
REQ-036 Backpressure: out_ack=0 for 3 cycles after beat 2 of requester 1 -> out_data stable, req_ack=0000, beat_cnt=2 held; burst resumes at beat 3.
REQ-037 Early drop: requester 3 drops req_vld after 2 beats while requester 0 is pending -> return to IDLE, rr_ptr=0, next grant=0.
REQ-038 Reset mid-burst at beat 1 of requester 1 -> next cycle state=IDLE, rr_ptr=0; next grant goes to the lowest requesting index.

Source files
------------

// File: rtl/leaf_arb_pkg.sv
// rtl/leaf_arb_pkg.sv - shared FSM state type and default sizing for the leaf output-port arbiter
package leaf_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int DEF_NUM_REQ      = 4;
   localparam int DEF_PAYLOAD_BITS = 32;
   localparam int DEF_MAX_BURST    = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority selector: first set request at or after ptr
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          any_req
);

   logic [IW-1:0] cand;

   // Scan from farthest to nearest so the closest hit to ptr wins.
   always_comb begin
      idx     = ptr;
      any_req = |req;
      cand    = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = IW'((int'(ptr) + k) % N);
         if (req[cand]) begin
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/leaf_out_port_arbiter.sv
// rtl/leaf_out_port_arbiter.sv - round-robin burst arbiter of NUM_REQ user streams onto one leaf output port
module leaf_out_port_arbiter
   import leaf_arb_pkg::*;
#(
   parameter int NUM_REQ      = DEF_NUM_REQ,
   parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
   parameter int MAX_BURST    = DEF_MAX_BURST,
   localparam int IW          = $clog2(NUM_REQ),
   localparam int BW          = $clog2(MAX_BURST) + 1
) (
   input  logic                            clk_user,
   input  logic                            reset,
   input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
   input  logic [NUM_REQ-1:0]              req_vld,
   output logic [NUM_REQ-1:0]              req_ack,
   output logic [PAYLOAD_BITS-1:0]         out_data,
   output logic                            out_vld,
   input  logic                            out_ack,
   output logic [IW-1:0]                   grant_idx,
   output logic                            busy
);

   localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

   arb_state_t    state, state_n;
   logic [IW-1:0] rr_ptr, rr_ptr_n;
   logic [IW-1:0] grant_idx_n;
   logic [IW-1:0] pick_idx;
   logic [IW-1:0] next_ptr;
   logic [BW-1:0] beat_cnt, beat_cnt_n;
   logic          any_req;
   logic          xfer;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr_pick (
      .req     (req_vld),
      .ptr     (rr_ptr),
      .idx     (pick_idx),
      .any_req (any_req)
   );

   assign next_ptr = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
   assign out_data = req_data[int'(grant_idx)*PAYLOAD_BITS +: PAYLOAD_BITS];
   assign busy     = (state == GRANT);

   always_comb begin
      state_n     = state;
      rr_ptr_n    = rr_ptr;
      grant_idx_n = grant_idx;
      beat_cnt_n  = beat_cnt;
      out_vld     = 1'b0;
      req_ack     = '0;
      xfer        = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_n     = GRANT;
               grant_idx_n = pick_idx;
               beat_cnt_n  = '0;
            end
         end
         GRANT: begin
            out_vld            = req_vld[grant_idx];
            req_ack[grant_idx] = out_ack;
            xfer               = out_vld & out_ack;
            if (!req_vld[grant_idx]) begin
               state_n  = IDLE;
               rr_ptr_n = next_ptr;
            end else if (xfer) begin
               beat_cnt_n = beat_cnt + 1'b1;
               if (beat_cnt == LAST_BEAT) begin
                  state_n  = IDLE;
                  rr_ptr_n = next_ptr;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      // A reset cycle aborts the burst: nothing is offered or acknowledged.
      if (reset) begin
         out_vld = 1'b0;
         req_ack = '0;
      end
   end

   always_ff @(posedge clk_user) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         grant_idx <= '0;
         beat_cnt  <= '0;
      end else begin
         state     <= state_n;
         rr_ptr    <= rr_ptr_n;
         grant_idx <= grant_idx_n;
         beat_cnt  <= beat_cnt_n;
      end
   end

endmodule

// File: tb/tb_leaf_out_port_arbiter.sv
// tb/tb_leaf_out_port_arbiter.sv - directed table and sequence bench for the leaf output-port arbiter
module tb_leaf_out_port_arbiter;

   localparam int NR = 4;
   localparam int PB = 32;
   localparam int MB = 4;

   logic             clk_user = 1'b0;
   logic             reset    = 1'b1;
   logic [NR*PB-1:0] req_data = '0;
   logic [NR-1:0]    req_vld  = '0;
   logic [NR-1:0]    req_ack;
   logic [PB-1:0]    out_data;
   logic             out_vld;
   logic             out_ack  = 1'b0;
   logic [1:0]       grant_idx;
   logic             busy;

   int n_chk = 0;
   int n_bad = 0;

   leaf_out_port_arbiter #(
      .NUM_REQ      (NR),
      .PAYLOAD_BITS (PB),
      .MAX_BURST    (MB)
   ) dut (
      .clk_user  (clk_user),
      .reset     (reset),
      .req_data  (req_data),
      .req_vld   (req_vld),
      .req_ack   (req_ack),
      .out_data  (out_data),
      .out_vld   (out_vld),
      .out_ack   (out_ack),
      .grant_idx (grant_idx),
      .busy      (busy)
   );

   always #5 clk_user = ~clk_user;

   typedef struct {
      logic        rst;
      logic [3:0]  vld;
      logic        ack;
      logic        ev;
      logic [3:0]  eack;
      logic        ebusy;
      logic [1:0]  eg;
      logic [31:0] ed;
   } vec_t;

   vec_t tbl[28];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk_user); #1;
      reset   = 1'b1;
      req_vld = '0;
      repeat (2) begin
         @(posedge clk_user); #1;
      end
      reset = 1'b0;
   endtask

   task automatic next_cyc();
      @(posedge clk_user); #1;
   endtask

   initial begin
      int          r;
      int          w;
      logic        took;
      logic [8:0]  ev_a;
      logic [31:0] ed_a[9];
      logic [8:0]  ack_b;
      logic [8:0]  ev_b;
      logic [8:0]  ak_b;
      logic [31:0] ed_b[9];

      // Reset with everyone requesting, then four-way contention: 0,1,2,3,0.
      tbl[0] = '{1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 32'h0};
      tbl[1] = '{1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 32'h0};
      tbl[2] = '{1'b0, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 32'h0};
      r = 3;
      for (int g = 0; g < 5; g++) begin
         for (int b = 0; b < MB; b++) begin
            tbl[r] = '{1'b0, 4'hF, 1'b1, 1'b1, 4'(1 << (g % 4)), 1'b1, 2'(g % 4), 32'hA000_0000 + 32'(g % 4)};
            r++;
         end
         tbl[r] = '{1'b0, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 2'(g % 4), 32'h0};
         r++;
      end

      for (int i = 0; i < NR; i++) req_data[i*PB +: PB] = 32'hA000_0000 + 32'(i);

      for (int i = 0; i < 28; i++) begin
         @(posedge clk_user); #1;
         reset   = tbl[i].rst;
         req_vld = tbl[i].vld;
         out_ack = tbl[i].ack;
         @(negedge clk_user);
         chk($sformatf("t%0d_vld", i), 32'(out_vld), 32'(tbl[i].ev));
         chk($sformatf("t%0d_ack", i), 32'(req_ack), 32'(tbl[i].eack));
         chk($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].ebusy));
         chk($sformatf("t%0d_gidx", i), 32'(grant_idx), 32'(tbl[i].eg));
         if (tbl[i].ev) chk($sformatf("t%0d_data", i), out_data, tbl[i].ed);
      end

      // Single stream from requester 2: 4-beat burst, one bubble, 2 more beats.
      do_reset();
      ev_a = 9'b0_1101_1110;
      ed_a = '{32'h0, 32'h10, 32'h11, 32'h12, 32'h13, 32'h0, 32'h14, 32'h15, 32'h0};
      req_vld = 4'b0100;
      out_ack = 1'b1;
      req_data[2*PB +: PB] = 32'h10;
      w = 0;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk_user);
         chk($sformatf("s%0d_vld", c), 32'(out_vld), 32'(ev_a[c]));
         if (ev_a[c]) begin
            chk($sformatf("s%0d_data", c), out_data, ed_a[c]);
            chk($sformatf("s%0d_gidx", c), 32'(grant_idx), 32'd2);
            chk($sformatf("s%0d_ack", c), 32'(req_ack), 32'b0100);
         end
         took = req_ack[2];
         next_cyc();
         if (took) begin
            w++;
            if (w >= 6) req_vld[2] = 1'b0;
            else req_data[2*PB +: PB] = 32'h10 + 32'(w);
         end
      end

      // Backpressure on requester 1 after two beats, three stalled cycles.
      do_reset();
      ack_b = 9'b1_1100_0111;
      ev_b  = 9'b0_1111_1110;
      ak_b  = 9'b0_1100_0110;
      ed_b  = '{32'h0, 32'h20, 32'h21, 32'h22, 32'h22, 32'h22, 32'h22, 32'h23, 32'h0};
      req_vld = 4'b0010;
      req_data[1*PB +: PB] = 32'h20;
      w = 0;
      for (int c = 0; c < 9; c++) begin
         out_ack = ack_b[c];
         @(negedge clk_user);
         chk($sformatf("b%0d_vld", c), 32'(out_vld), 32'(ev_b[c]));
         chk($sformatf("b%0d_ack", c), 32'(req_ack), ak_b[c] ? 32'b0010 : 32'b0000);
         if (ev_b[c]) chk($sformatf("b%0d_data", c), out_data, ed_b[c]);
         if (c >= 3 && c <= 6) chk($sformatf("b%0d_beat", c), 32'(dut.beat_cnt), 32'd2);
         if (c == 7) chk("b7_beat", 32'(dut.beat_cnt), 32'd3);
         took = req_ack[1];
         next_cyc();
         if (took) begin
            w++;
            req_data[1*PB +: PB] = 32'h20 + 32'(w);
         end
      end

      // Requester 3 drops after two beats while requester 0 waits.
      do_reset();
      out_ack = 1'b1;
      req_vld = 4'b1000;
      req_data[3*PB +: PB] = 32'h30;
      req_data[0*PB +: PB] = 32'h40;
      @(negedge clk_user);
      chk("d0_busy", 32'(busy), 32'd0);
      next_cyc();
      req_vld[0] = 1'b1;
      @(negedge clk_user);
      chk("d1_gidx", 32'(grant_idx), 32'd3);
      chk("d1_data", out_data, 32'h30);
      chk("d1_ack", 32'(req_ack), 32'b1000);
      next_cyc();
      req_data[3*PB +: PB] = 32'h31;
      @(negedge clk_user);
      chk("d2_gidx", 32'(grant_idx), 32'd3);
      chk("d2_data", out_data, 32'h31);
      next_cyc();
      req_vld[3] = 1'b0;
      @(negedge clk_user);
      chk("d3_busy", 32'(busy), 32'd1);
      chk("d3_vld", 32'(out_vld), 32'd0);
      next_cyc();
      @(negedge clk_user);
      chk("d4_busy", 32'(busy), 32'd0);
      chk("d4_rrptr", 32'(dut.rr_ptr), 32'd0);
      chk("d4_gidx", 32'(grant_idx), 32'd3);
      next_cyc();
      @(negedge clk_user);
      chk("d5_gidx", 32'(grant_idx), 32'd0);
      chk("d5_data", out_data, 32'h40);
      chk("d5_ack", 32'(req_ack), 32'b0001);

      // Reset during beat 1 of requester 1.
      do_reset();
      for (int i = 0; i < NR; i++) req_data[i*PB +: PB] = 32'hA000_0000 + 32'(i);
      req_vld = 4'hF;
      out_ack = 1'b1;
      repeat (6) next_cyc();
      @(negedge clk_user);
      chk("r6_gidx", 32'(grant_idx), 32'd1);
      chk("r6_ack", 32'(req_ack), 32'b0010);
      next_cyc();
      reset = 1'b1;
      @(negedge clk_user);
      chk("r7_beat", 32'(dut.beat_cnt), 32'd1);
      chk("r7_vld", 32'(out_vld), 32'd0);
      chk("r7_ack", 32'(req_ack), 32'd0);
      next_cyc();
      reset = 1'b0;
      @(negedge clk_user);
      chk("r8_busy", 32'(busy), 32'd0);
      chk("r8_rrptr", 32'(dut.rr_ptr), 32'd0);
      chk("r8_gidx", 32'(grant_idx), 32'd0);
      chk("r8_beat", 32'(dut.beat_cnt), 32'd0);
      next_cyc();
      @(negedge clk_user);
      chk("r9_busy", 32'(busy), 32'd1);
      chk("r9_gidx", 32'(grant_idx), 32'd0);
      chk("r9_ack", 32'(req_ack), 32'b0001);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
